// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared sizes and word offset helper for the register file write port
package rf_pkg;
  localparam int N_REGS  = 8;
  localparam int DATA_W  = 16;
  localparam int SEL_W   = 3;
  localparam int TOTAL_W = N_REGS * DATA_W;

  localparam logic [0:0] STG_EMPTY = 1'b0;
  localparam logic [0:0] STG_FULL  = 1'b1;

  // Bit offset of register sel inside the flat bus.
  function automatic int word_off(input logic [SEL_W-1:0] sel);
    return DATA_W * int'(sel);
  endfunction
endpackage

// File: rtl/dec3_8.sv
// rtl/dec3_8.sv - combinational 3-to-8 one-hot decoder with enable
module dec3_8
  import rf_pkg::*;
(
  input  logic              i_en,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [N_REGS-1:0] o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end
endmodule

// File: rtl/rf_write_port.sv
// rtl/rf_write_port.sv - staged write side of the 8 x 16-bit register file
module rf_write_port
  import rf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               commit_en,
  output logic [TOTAL_W-1:0] regs_flat,
  output logic [TOTAL_W-1:0] regs_byp,
  output logic [N_REGS-1:0]  wr_mask,
  output logic               stg_busy
);
  logic [0:0]        r_stg_state;
  logic [SEL_W-1:0]  r_stg_sel;
  logic [DATA_W-1:0] r_stg_data;
  logic [N_REGS-1:0] r_wr_mask;
  logic [DATA_W-1:0] r_storage [N_REGS];

  logic              w_stg_valid;
  logic              w_accept;
  logic              w_commit;
  logic [N_REGS-1:0] w_commit_onehot;

  assign w_stg_valid = (r_stg_state == STG_FULL);
  assign wr_ready    = !w_stg_valid || commit_en;
  assign w_accept    = wr_valid && wr_ready;
  assign w_commit    = w_stg_valid && commit_en;
  assign stg_busy    = w_stg_valid;
  assign wr_mask     = r_wr_mask;

  // A commit and a new accept on the same edge retire the old entry and refill the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_state <= STG_EMPTY;
      r_stg_sel   <= '0;
      r_stg_data  <= '0;
    end else if (w_accept) begin
      r_stg_state <= STG_FULL;
      r_stg_sel   <= wr_sel;
      r_stg_data  <= wr_data;
    end else if (w_commit) begin
      r_stg_state <= STG_EMPTY;
    end
  end

  dec3_8 u_commit_dec (
    .i_en     (w_commit),
    .i_sel    (r_stg_sel),
    .o_onehot (w_commit_onehot)
  );

  genvar g;
  generate
    for (g = 0; g < N_REGS; g = g + 1) begin : g_word
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_storage[g] <= '0;
        else if (w_commit_onehot[g]) r_storage[g] <= r_stg_data;
      end
      assign regs_flat[word_off(SEL_W'(g)) +: DATA_W] = r_storage[g];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wr_mask <= '0;
    else     r_wr_mask <= r_wr_mask | w_commit_onehot;
  end

  always_comb begin
    regs_byp = regs_flat;
    if (w_stg_valid) regs_byp[word_off(r_stg_sel) +: DATA_W] = r_stg_data;
  end
endmodule

// File: tb/tb_rf_write_port.sv
// tb/tb_rf_write_port.sv - scoreboard bench for rf_write_port
module tb_rf_write_port;
  import rf_pkg::*;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_valid;
  logic               wr_ready;
  logic [SEL_W-1:0]   wr_sel;
  logic [DATA_W-1:0]  wr_data;
  logic               commit_en;
  logic [TOTAL_W-1:0] regs_flat;
  logic [TOTAL_W-1:0] regs_byp;
  logic [N_REGS-1:0]  wr_mask;
  logic               stg_busy;

  wr_t               sb[$];
  logic [DATA_W-1:0] m_store [N_REGS];
  logic [N_REGS-1:0] m_mask;
  int                checks = 0;
  int                errors = 0;

  rf_write_port dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .commit_en (commit_en),
    .regs_flat (regs_flat),
    .regs_byp  (regs_byp),
    .wr_mask   (wr_mask),
    .stg_busy  (stg_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [TOTAL_W-1:0] model_flat();
    logic [TOTAL_W-1:0] f;
    for (int r = 0; r < N_REGS; r++) f[r*DATA_W +: DATA_W] = m_store[r];
    return f;
  endfunction

  function automatic logic [TOTAL_W-1:0] model_byp();
    logic [TOTAL_W-1:0] f;
    f = model_flat();
    if (sb.size() != 0) f[int'(sb[0].sel)*DATA_W +: DATA_W] = sb[0].data;
    return f;
  endfunction

  task automatic model_clear();
    sb.delete();
    for (int r = 0; r < N_REGS; r++) m_store[r] = '0;
    m_mask = '0;
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d, input logic c);
    wr_valid  = v;
    wr_sel    = s;
    wr_data   = d;
    commit_en = c;
  endtask

  // One clock: predict commit/accept from bench state, advance the model, settle 1 ns past the edge.
  task automatic tick();
    logic com;
    logic acc;
    wr_t  e;
    com = (sb.size() != 0) && commit_en;
    acc = wr_valid && ((sb.size() == 0) || commit_en);
    @(posedge clk);
    if (com) begin
      e = sb.pop_front();
      m_store[e.sel] = e.data;
      m_mask[e.sel]  = 1'b1;
    end
    if (acc) sb.push_back('{sel: wr_sel, data: wr_data});
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_flat got %h exp 0", regs_flat); end
    checks++; if (regs_byp !== '0) begin errors++; $display("FAIL reset_byp got %h exp 0", regs_byp); end
    checks++; if (wr_mask !== 8'h00) begin errors++; $display("FAIL reset_mask got %h exp 00", wr_mask); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
    checks++; if (stg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", stg_busy); end
    rst = 1'b0;
    drive(1'b1, 3'd3, 16'hBEEF, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    #1;
    checks++; if (stg_busy !== 1'b1) begin errors++; $display("FAIL staged_busy got %b exp 1", stg_busy); end
    checks++; if (regs_byp[63:48] !== 16'hBEEF) begin errors++; $display("FAIL staged_byp_r3 got %h exp beef", regs_byp[63:48]); end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL midrst_flat got %h exp 0", regs_flat); end
    checks++; if (regs_byp !== '0) begin errors++; $display("FAIL midrst_byp got %h exp 0", regs_byp); end
    checks++; if (wr_mask !== 8'h00) begin errors++; $display("FAIL midrst_mask got %h exp 00", wr_mask); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", wr_ready); end
    rst = 1'b0;
    commit_en = 1'b1;
    tick();
    tick();
    checks++; if (regs_flat[63:48] !== 16'h0000) begin errors++; $display("FAIL postrst_r3 got %h exp 0000", regs_flat[63:48]); end
    checks++; if (wr_mask !== m_mask) begin errors++; $display("FAIL postrst_mask got %h exp %h", wr_mask, m_mask); end
  endtask

  task automatic test_single_write();
    drive(1'b1, 3'd5, 16'h1234, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    #1;
    checks++; if (regs_byp[95:80] !== 16'h1234) begin errors++; $display("FAIL single_byp got %h exp 1234", regs_byp[95:80]); end
    checks++; if (regs_flat[95:80] !== 16'h0000) begin errors++; $display("FAIL single_flat_early got %h exp 0000", regs_flat[95:80]); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL single_ready_full got %b exp 0", wr_ready); end
    checks++; if (regs_byp !== model_byp()) begin errors++; $display("FAIL single_byp_all got %h exp %h", regs_byp, model_byp()); end
    commit_en = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready_commit got %b exp 1", wr_ready); end
    tick();
    checks++; if (regs_flat[95:80] !== 16'h1234) begin errors++; $display("FAIL single_flat got %h exp 1234", regs_flat[95:80]); end
    checks++; if (wr_mask !== 8'h20) begin errors++; $display("FAIL single_mask got %h exp 20", wr_mask); end
    checks++; if (stg_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", stg_busy); end
  endtask

  task automatic test_back_pressure();
    drive(1'b1, 3'd1, 16'h5555, 1'b0);
    tick();
    drive(1'b1, 3'd2, 16'hAAAA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, wr_ready); end
      tick();
      checks++; if (regs_byp[47:32] !== model_byp()[47:32] || regs_byp[31:16] !== 16'h5555) begin
        errors++; $display("FAIL bp_hold[%0d] got r1=%h r2=%h exp r1=5555 r2=%h", i, regs_byp[31:16], regs_byp[47:32], model_byp()[47:32]);
      end
    end
    commit_en = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", wr_ready); end
    tick();
    checks++; if (regs_flat[31:16] !== 16'h5555) begin errors++; $display("FAIL bp_commit_r1 got %h exp 5555", regs_flat[31:16]); end
    checks++; if (regs_byp[47:32] !== 16'hAAAA || stg_busy !== 1'b1) begin
      errors++; $display("FAIL bp_accept_r2 got %h busy %b exp aaaa busy 1", regs_byp[47:32], stg_busy);
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    checks++; if (regs_flat[47:32] !== 16'hAAAA) begin errors++; $display("FAIL bp_commit_r2 got %h exp aaaa", regs_flat[47:32]); end
    checks++; if (stg_busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got %b exp 0", stg_busy); end
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] v;
    for (int r = 0; r < N_REGS; r++) begin
      v = 16'h1000 + 16'(r);
      drive(1'b1, SEL_W'(r), v, 1'b1);
      tick();
      if (r == N_REGS - 1) begin
        checks++; if (regs_flat[127:112] !== 16'h0000) begin errors++; $display("FAIL stream_r7_early got %h exp 0000", regs_flat[127:112]); end
      end
    end
    drive(1'b0, 3'd6, 16'hDEAD, 1'b1);
    tick();
    checks++; if (wr_mask !== 8'hFF) begin errors++; $display("FAIL stream_mask got %h exp ff", wr_mask); end
    checks++; if (stg_busy !== 1'b0) begin errors++; $display("FAIL stream_busy got %b exp 0", stg_busy); end
    for (int r = 0; r < N_REGS; r++) begin
      v = 16'h1000 + 16'(r);
      checks++; if (regs_flat[r*DATA_W +: DATA_W] !== v) begin
        errors++; $display("FAIL stream_word[%0d] got %h exp %h", r, regs_flat[r*DATA_W +: DATA_W], v);
      end
    end
    checks++; if (regs_flat !== model_flat()) begin errors++; $display("FAIL stream_flat got %h exp %h", regs_flat, model_flat()); end
  endtask

  task automatic test_same_reg();
    logic [TOTAL_W-1:0] snap;
    snap = model_flat();
    drive(1'b1, 3'd7, 16'h0001, 1'b1);
    tick();
    drive(1'b1, 3'd7, 16'h0002, 1'b1);
    tick();
    checks++; if (regs_byp[127:112] !== 16'h0002) begin errors++; $display("FAIL same_byp got %h exp 0002", regs_byp[127:112]); end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    checks++; if (regs_flat[127:112] !== 16'h0002) begin errors++; $display("FAIL same_r7 got %h exp 0002", regs_flat[127:112]); end
    checks++; if (regs_flat[111:0] !== snap[111:0]) begin errors++; $display("FAIL same_others got %h exp %h", regs_flat[111:0], snap[111:0]); end
  endtask

  task automatic test_boundary();
    logic [TOTAL_W-1:0] snap;
    snap = model_flat();
    drive(1'b1, 3'd0, 16'hFFFF, 1'b1);
    tick();
    drive(1'b1, 3'd7, 16'h8001, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    checks++; if (regs_flat[15:0] !== 16'hFFFF) begin errors++; $display("FAIL bound_r0 got %h exp ffff", regs_flat[15:0]); end
    checks++; if (regs_flat[127:112] !== 16'h8001) begin errors++; $display("FAIL bound_r7 got %h exp 8001", regs_flat[127:112]); end
    checks++; if (regs_flat[111:16] !== snap[111:16]) begin errors++; $display("FAIL bound_mid got %h exp %h", regs_flat[111:16], snap[111:16]); end
    if (sb.size() == 0) begin
      checks++; if (regs_byp !== model_flat()) begin errors++; $display("FAIL bound_byp_idle got %h exp %h", regs_byp, model_flat()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_pressure();
    test_streaming();
    test_same_reg();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
